// File: rtl/data_memory_pkg.sv
// Shared types, default geometry and the write-priority helper for the AAP data memory.
package data_memory_pkg;

   typedef enum logic {
      DM_CLEAR = 1'b0,
      DM_RUN   = 1'b1
   } dm_state_e;

   localparam int DM_DATA_W = 16;
   localparam int DM_ADDR_W = 9;
   localparam int DM_DEPTH  = 512;
   localparam int DM_N_RD   = 4;
   localparam int DM_N_WR   = 4;
   localparam int DM_MAX_WR = 32;

   // Highest-index port whose bit is set in hit owns the address; 0 when none hit.
   function automatic int dm_win_port(input logic [DM_MAX_WR-1:0] hit);
      dm_win_port = 0;
      for (int q = 0; q < DM_MAX_WR; q++) begin
         dm_win_port = hit[q] ? q : dm_win_port;
      end
   endfunction

endpackage

// File: rtl/data_memory_clear_seq.sv
// Post-reset clear sweep: walks clr_addr 0..DEPTH-1 once, then holds RUN and raises ready.
module data_memory_clear_seq
   import data_memory_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DEPTH  = DM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   output dm_state_e         state,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   dm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              ready_q, ready_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         DM_CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = DM_RUN;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
         end
         DM_RUN: begin
            state_d = DM_RUN;
         end
         default: begin
            state_d    = DM_CLEAR;
            clr_addr_d = '0;
         end
      endcase
      ready_d = (state_d == DM_RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= DM_CLEAR;
         clr_addr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         ready_q    <= ready_d;
      end
   end

   assign state    = state_q;
   assign clr_addr = clr_addr_q;
   assign ready    = ready_q;

endmodule

// File: rtl/data_memory_multiport.sv
// Parametrised N_RD x N_WR data memory with registered reads and a post-reset clear sweep.
// Define DATA_MEMORY_WRITE_FORWARD_EN to forward same-cycle write data onto colliding reads.
module data_memory_multiport
   import data_memory_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W,
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DEPTH  = DM_DEPTH,
   parameter int N_RD   = DM_N_RD,
   parameter int N_WR   = DM_N_WR
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_RD-1:0]          rd_en,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_valid,
   input  logic [N_WR-1:0]          wr_en,
   input  logic [N_WR*ADDR_W-1:0]   wr_addr,
   input  logic [N_WR*DATA_W-1:0]   wr_data,
   output logic                     ready,
   output logic                     wr_conflict,
   output logic                     addr_err
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      in_range = ({1'b0, a} < DEPTH_L);
   endfunction

   dm_state_e         state_s;
   logic [ADDR_W-1:0] clr_addr_s;
   logic              run_s;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] rd_addr_s [N_RD];
   logic [ADDR_W-1:0] wr_addr_s [N_WR];
   logic [DATA_W-1:0] wr_data_s [N_WR];
   logic [N_WR-1:0]   wr_ok_s;

   logic [DATA_W-1:0] rd_data_q [N_RD];
   logic [DATA_W-1:0] rd_data_d [N_RD];
   logic [N_RD-1:0]   rd_valid_q, rd_valid_d;
   logic              wr_conflict_q, wr_conflict_d;
   logic              addr_err_q, addr_err_d;

   data_memory_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clock    (clock),
      .reset    (reset),
      .state    (state_s),
      .clr_addr (clr_addr_s),
      .ready    (ready)
   );

   assign run_s = (state_s == DM_RUN);

   // Unpack port buses; a write only qualifies in RUN with an in-range address.
   always_comb begin
      for (int q = 0; q < N_WR; q++) begin
         wr_addr_s[q] = wr_addr[q*ADDR_W +: ADDR_W];
         wr_data_s[q] = wr_data[q*DATA_W +: DATA_W];
         wr_ok_s[q]   = run_s & wr_en[q] & in_range(wr_addr[q*ADDR_W +: ADDR_W]);
      end
      for (int p = 0; p < N_RD; p++) begin
         rd_addr_s[p] = rd_addr[p*ADDR_W +: ADDR_W];
      end
   end

   // Later loop iterations override earlier ones, so the highest-index writer lands last.
   always_ff @(posedge clock) begin
      if (state_s == DM_CLEAR) begin
         mem_q[clr_addr_s] <= '0;
      end else begin
         for (int q = 0; q < N_WR; q++) begin
            if (wr_ok_s[q]) begin
               mem_q[wr_addr_s[q]] <= wr_data_s[q];
            end
         end
      end
   end

   // Read data selection; idle ports keep their previous data.
   always_comb begin
`ifdef DATA_MEMORY_WRITE_FORWARD_EN
      logic [DM_MAX_WR-1:0] hit_s;
      int                   win_s;
      hit_s = '0;
      win_s = 0;
`endif
      for (int p = 0; p < N_RD; p++) begin
         rd_valid_d[p] = run_s & rd_en[p];
         if (!(run_s && rd_en[p])) begin
            rd_data_d[p] = rd_data_q[p];
         end else if (!in_range(rd_addr_s[p])) begin
            rd_data_d[p] = '0;
         end else begin
            rd_data_d[p] = mem_q[rd_addr_s[p]];
`ifdef DATA_MEMORY_WRITE_FORWARD_EN
            hit_s = '0;
            for (int q = 0; q < N_WR; q++) begin
               hit_s[q] = wr_ok_s[q] & (wr_addr_s[q] == rd_addr_s[p]);
            end
            win_s = dm_win_port(hit_s);
            for (int q = 0; q < N_WR; q++) begin
               rd_data_d[p] = ((|hit_s) && (q == win_s)) ? wr_data_s[q] : rd_data_d[p];
            end
`endif
         end
      end
   end

   // Collision and range flags, raised only while the memory is live.
   always_comb begin
      wr_conflict_d = 1'b0;
      addr_err_d    = 1'b0;
      if (run_s) begin
         for (int q = 0; q < N_WR; q++) begin
            addr_err_d = addr_err_d | (wr_en[q] & ~in_range(wr_addr_s[q]));
            for (int r = q + 1; r < N_WR; r++) begin
               wr_conflict_d = wr_conflict_d |
                               (wr_en[q] & wr_en[r] & (wr_addr_s[q] == wr_addr_s[r]));
            end
         end
         for (int p = 0; p < N_RD; p++) begin
            addr_err_d = addr_err_d | (rd_en[p] & ~in_range(rd_addr_s[p]));
         end
      end else begin
         wr_conflict_d = 1'b0;
         addr_err_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < N_RD; p++) begin
            rd_data_q[p] <= '0;
         end
         rd_valid_q    <= '0;
         wr_conflict_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         for (int p = 0; p < N_RD; p++) begin
            rd_data_q[p] <= rd_data_d[p];
         end
         rd_valid_q    <= rd_valid_d;
         wr_conflict_q <= wr_conflict_d;
         addr_err_q    <= addr_err_d;
      end
   end

   always_comb begin
      for (int p = 0; p < N_RD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = rd_data_q[p];
      end
   end

   assign rd_valid    = rd_valid_q;
   assign wr_conflict = wr_conflict_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_data_memory_multiport.sv
// Bench for data_memory_multiport: a full-size (DEPTH=512) and a short (DEPTH=300) instance
// share stimulus and are both checked every cycle against a behavioural model.
module tb_data_memory_multiport;

   localparam int DW = 16;
   localparam int AW = 9;
   localparam int NR = 4;
   localparam int NW = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;

   logic [NR*DW-1:0]  rd_data_a, rd_data_b;
   logic [NR-1:0]     rd_valid_a, rd_valid_b;
   logic              ready_a, ready_b, conf_a, conf_b, err_a, err_b;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_on = 1'b0;

   data_memory_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .N_RD(NR), .N_WR(NW)) dut_a (
      .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ready(ready_a), .wr_conflict(conf_a), .addr_err(err_a));

   data_memory_multiport #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(300), .N_RD(NR), .N_WR(NW)) dut_b (
      .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ready(ready_b), .wr_conflict(conf_b), .addr_err(err_b));

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_mem  [2][512];
   int            m_cnt  [2];
   logic          m_ready[2];
   logic [NR-1:0] m_valid[2];
   logic [DW-1:0] m_data [2][NR];
   logic          m_conf [2];
   logic          m_err  [2];

   function automatic int depth_of(input int i);
      return (i == 0) ? 512 : 300;
   endfunction

   task automatic model_step(input int i);
      int d, ra, wa, wb;
      logic [DW-1:0] v;
      d = depth_of(i);
      if (reset) begin
         m_cnt[i] = 0; m_ready[i] = 1'b0; m_valid[i] = '0; m_conf[i] = 1'b0; m_err[i] = 1'b0;
         for (int p = 0; p < NR; p++) m_data[i][p] = '0;
         for (int a = 0; a < 512; a++) m_mem[i][a] = '0;
      end else if (m_cnt[i] < d) begin
         m_cnt[i] = m_cnt[i] + 1;
         m_valid[i] = '0; m_conf[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
         m_conf[i] = 1'b0; m_err[i] = 1'b0;
         for (int p = 0; p < NR; p++) begin
            m_valid[i][p] = rd_en[p];
            if (rd_en[p]) begin
               ra = int'(rd_addr[p*AW +: AW]);
               if (ra >= d) begin
                  m_data[i][p] = '0; m_err[i] = 1'b1;
               end else begin
                  v = m_mem[i][ra];
`ifdef DATA_MEMORY_WRITE_FORWARD_EN
                  for (int q = 0; q < NW; q++)
                     if (wr_en[q] && int'(wr_addr[q*AW +: AW]) == ra) v = wr_data[q*DW +: DW];
`endif
                  m_data[i][p] = v;
               end
            end
         end
         for (int q = 0; q < NW; q++) begin
            wa = int'(wr_addr[q*AW +: AW]);
            if (wr_en[q] && wa >= d) m_err[i] = 1'b1;
            for (int r = q + 1; r < NW; r++) begin
               wb = int'(wr_addr[r*AW +: AW]);
               if (wr_en[q] && wr_en[r] && wa == wb) m_conf[i] = 1'b1;
            end
         end
         for (int q = 0; q < NW; q++) begin
            wa = int'(wr_addr[q*AW +: AW]);
            if (wr_en[q] && wa < d) m_mem[i][wa] = wr_data[q*DW +: DW];
         end
      end
      m_ready[i] = (m_cnt[i] >= d);
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s inst=%0d act=%0h exp=%0h t=%0t", nm, inst, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic [NR*DW-1:0] rdd, input logic [NR-1:0] rv,
                           input logic rdy, input logic cf, input logic er);
      check("ready", i, {31'd0, rdy}, {31'd0, m_ready[i]});
      check("rd_valid", i, {28'd0, rv}, {28'd0, m_valid[i]});
      check("wr_conflict", i, {31'd0, cf}, {31'd0, m_conf[i]});
      check("addr_err", i, {31'd0, er}, {31'd0, m_err[i]});
      for (int p = 0; p < NR; p++)
         check("rd_data", i, {16'd0, rdd[p*DW +: DW]}, {16'd0, m_data[i][p]});
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (chk_on) begin
            cmp_inst(0, rd_data_a, rd_valid_a, ready_a, conf_a, err_a);
            cmp_inst(1, rd_data_b, rd_valid_b, ready_b, conf_b, err_b);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic set_wr(input int q, input int a, input logic [DW-1:0] d);
      wr_en[q] = 1'b1;
      wr_addr[q*AW +: AW] = AW'(a);
      wr_data[q*DW +: DW] = d;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   // Counts cycles from reset release until ready on each instance.
   task automatic wait_ready(output int na, output int nb);
      na = 0; nb = 0;
      while (!ready_a && na < 600) begin
         tick();
         na++;
         if (ready_b && nb == 0) nb = na;
      end
   endtask

   initial begin
      int na, nb;
      logic [DW-1:0] exp4;
      reset = 1'b1;
      idle();
      tick(); tick();
      chk_on = 1'b1;
      tick();
      check("reset_ready", 0, {31'd0, ready_a}, 32'd0);
      check("reset_rd_data", 0, {16'd0, rd_data_a[15:0]}, 32'd0);

      // 1: sweep length, then every address reads zero
      set_wr(0, 3, 16'h5555); set_rd(0, 3);
      reset = 1'b0;
      wait_ready(na, nb);
      idle();
      check("clear_len", 0, na, 32'd512);
      check("clear_len", 1, nb, 32'd300);
      for (int a = 0; a < 128; a++) begin
         for (int p = 0; p < NR; p++) set_rd(p, 4 * a + p);
         tick();
         for (int p = 0; p < NR; p++) begin
            check("clear_zero", 0, {16'd0, rd_data_a[p*DW +: DW]}, 32'd0);
            check("clear_valid", 0, {28'd0, rd_valid_a}, 32'hF);
         end
      end
      idle(); tick();

      // 2: write then broadcast read
      set_wr(0, 5, 16'hBEEF); tick(); idle();
      for (int p = 0; p < NR; p++) set_rd(p, 5);
      tick(); idle();
      for (int p = 0; p < NR; p++) check("beef", 0, {16'd0, rd_data_a[p*DW +: DW]}, 32'hBEEF);
      check("beef_valid", 0, {28'd0, rd_valid_a}, 32'hF);
      tick();
      check("valid_drop", 0, {28'd0, rd_valid_a}, 32'h0);
      check("data_hold", 0, {16'd0, rd_data_a[15:0]}, 32'hBEEF);

      // 3: write collision
      set_wr(0, 9, 16'h1111); set_wr(3, 9, 16'h3333); tick(); idle();
      check("conflict_pulse", 0, {31'd0, conf_a}, 32'd1);
      tick();
      check("conflict_end", 0, {31'd0, conf_a}, 32'd0);
      set_rd(1, 9); tick(); idle();
      check("conflict_win", 0, {16'd0, rd_data_a[1*DW +: DW]}, 32'h3333);

      // 4: read/write same address same cycle
      set_wr(0, 7, 16'h0001); tick(); idle();
      set_wr(1, 7, 16'hAAAA); set_rd(0, 7); tick(); idle();
`ifdef DATA_MEMORY_WRITE_FORWARD_EN
      exp4 = 16'hAAAA;
`else
      exp4 = 16'h0001;
`endif
      check("rw_same", 0, {16'd0, rd_data_a[15:0]}, {16'd0, exp4});
      set_rd(0, 7); tick(); idle();
      check("rw_commit", 0, {16'd0, rd_data_a[15:0]}, 32'hAAAA);

      // 5: out-of-range on the DEPTH=300 instance
      set_wr(0, 400, 16'h1234); tick(); idle();
      check("oor_wr_err", 1, {31'd0, err_b}, 32'd1);
      check("inr_wr_err", 0, {31'd0, err_a}, 32'd0);
      tick();
      check("oor_err_end", 1, {31'd0, err_b}, 32'd0);
      set_rd(2, 400); tick(); idle();
      check("oor_rd_data", 1, {16'd0, rd_data_b[2*DW +: DW]}, 32'd0);
      check("oor_rd_valid", 1, {28'd0, rd_valid_b}, 32'h4);
      check("oor_rd_err", 1, {31'd0, err_b}, 32'd1);
      check("inr_rd_data", 0, {16'd0, rd_data_a[2*DW +: DW]}, 32'h1234);

      // 6: reset mid-sweep restarts it
      set_rd(0, 5); reset = 1'b1; tick(); reset = 1'b0; idle();
      check("rst_valid", 0, {28'd0, rd_valid_a}, 32'h0);
      for (int c = 0; c < 100; c++) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_mid_ready", 0, {31'd0, ready_a}, 32'd0);
      wait_ready(na, nb);
      check("reclear_len", 0, na, 32'd512);
      check("reclear_len", 1, nb, 32'd300);
      set_rd(0, 5); set_rd(1, 9); set_rd(2, 7); tick(); idle();
      check("reclear_5", 0, {16'd0, rd_data_a[0 +: DW]}, 32'd0);
      check("reclear_9", 0, {16'd0, rd_data_a[DW +: DW]}, 32'd0);
      check("reclear_7", 0, {16'd0, rd_data_a[2*DW +: DW]}, 32'd0);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
